// File: rtl/diag_rot_pkg.sv
// Shared definitions for the diagonal-rotation block cipher pair.
// dest_idx maps an encrypted block position to its decrypted buffer index.
package diag_rot_pkg;

    localparam int unsigned BLK_DIM  = 32;
    localparam int unsigned FRAME_W  = 640;
    localparam int unsigned KEY_BITS = 80;

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        LOAD,
        PRIME,
        WRITE,
        DONE
    } state_e;

    // b=0 undoes the down-right ring shift, b=1 undoes the down-left one.
    function automatic logic [9:0] dest_idx(input logic b, input logic [4:0] y,
                                            input logic [4:0] x);
        logic [4:0] dy;
        logic [4:0] dx;
        if (!b) begin
            if (y == 5'd0) begin
                dy = (x == 5'd31) ? 5'd0 : 5'd31 - x;
                dx = 5'd31;
            end else if (x == 5'd0) begin
                dy = 5'd31;
                dx = 5'd31 - y;
            end else begin
                dy = y - 5'd1;
                dx = x - 5'd1;
            end
        end else begin
            if (y == 5'd0) begin
                dy = x;
                dx = 5'd0;
            end else if (x == 5'd31) begin
                dy = 5'd31;
                dx = y;
            end else begin
                dy = y - 5'd1;
                dx = x + 5'd1;
            end
        end
        return {dy, dx};
    endfunction

endpackage

// File: rtl/diag_blk_buf.sv
// One-block staging buffer: simple dual-port RAM, synchronous read,
// no reset so it maps onto a block RAM.
module diag_blk_buf #(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 16
) (
    input  logic                 Clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [AddrWidth-1:0] raddr,
    output logic [DataWidth-1:0] rdata
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/diag_unrotation.sv
// In-place frame decryptor: per 32x32 block, read from SRAM through the inverse
// ring permutation into a buffer, then write the buffer back in raster order.
module diag_unrotation
    import diag_rot_pkg::*;
#(
    parameter int unsigned BLK_COLS  = 20,
    parameter int unsigned BLK_ROWS  = 15,
    parameter int unsigned KEY_ROWS  = 4,
    parameter logic [19:0] BASE_ADDR = 20'h0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run,
    input  logic [KEY_BITS-1:0] subkey,
    output logic                done,
    output logic                key_ack,
    input  logic [15:0]         SRAM_DQ_in,
    output logic [15:0]         SRAM_DQ_out,
    output logic                SRAM_DQ_imp,
    output logic [19:0]         SRAM_ADDR,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N
);

    localparam logic [31:0] ROW_STRIDE = 32'(BLK_DIM * BLK_COLS);
    localparam logic [7:0]  LAST_BX    = 8'(BLK_COLS - 1);
    localparam logic [7:0]  LAST_BY    = 8'(BLK_ROWS - 1);
    localparam logic [7:0]  LAST_KROW  = 8'(KEY_ROWS - 1);

    state_e state_q, state_d;

    logic [7:0]          bx_q, bx_d;
    logic [7:0]          by_q, by_d;
    logic [7:0]          krow_q, krow_d;
    logic [4:0]          x_q, x_d;
    logic [4:0]          y_q, y_d;
    logic [KEY_BITS-1:0] ksr_q, ksr_d;

    logic        blk_end;
    logic        last_blk;
    logic        key_load;
    logic [19:0] pix_addr;

    logic        buf_we;
    logic [9:0]  buf_waddr;
    logic [9:0]  buf_raddr;
    logic [15:0] buf_rdata;

    assign blk_end  = (y_q == 5'd31) && (x_q == 5'd31);
    assign last_blk = (bx_q == LAST_BX) && (by_q == LAST_BY);
    // A fresh subkey is needed at the first block of every key group.
    assign key_load = (bx_q == 8'd0) && (krow_q == 8'd0);

    assign pix_addr = BASE_ADDR
                    + 20'((((32'(by_q) << 5) + 32'(y_q)) * ROW_STRIDE))
                    + 20'({bx_q, 5'd0})
                    + 20'(x_q);

    // Encrypted pixel (y,x) lands at its plain position inside the buffer.
    assign buf_we    = (state_q == LOAD);
    assign buf_waddr = dest_idx(ksr_q[KEY_BITS-1], y_q, x_q);
    // Prefetch the next raster index so the data lines up with the SRAM write.
    assign buf_raddr = (state_q == WRITE) ? ({y_q, x_q} + 10'd1) : 10'd0;

    diag_blk_buf #(
        .AddrWidth(10),
        .DataWidth(16)
    ) u_buf (
        .Clk  (Clk),
        .we   (buf_we),
        .waddr(buf_waddr),
        .wdata(SRAM_DQ_in),
        .raddr(buf_raddr),
        .rdata(buf_rdata)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Run) state_d = KEY;
            KEY:     state_d = LOAD;
            LOAD:    if (blk_end) state_d = PRIME;
            PRIME:   state_d = WRITE;
            WRITE:   if (blk_end) state_d = last_blk ? DONE : KEY;
            DONE:    if (!Run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done        = 1'b0;
        key_ack     = 1'b0;
        SRAM_DQ_imp = 1'b1;
        SRAM_OE_N   = 1'b1;
        SRAM_WE_N   = 1'b1;
        SRAM_ADDR   = 20'h0;
        SRAM_DQ_out = 16'h0;
        unique case (state_q)
            KEY:  key_ack = key_load;
            LOAD: begin
                SRAM_OE_N = 1'b0;
                SRAM_ADDR = pix_addr;
            end
            WRITE: begin
                SRAM_WE_N   = 1'b0;
                SRAM_DQ_imp = 1'b0;
                SRAM_ADDR   = pix_addr;
                SRAM_DQ_out = buf_rdata;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        bx_d   = bx_q;
        by_d   = by_q;
        krow_d = krow_q;
        x_d    = x_q;
        y_d    = y_q;
        ksr_d  = ksr_q;
        unique case (state_q)
            IDLE: begin
                bx_d   = 8'd0;
                by_d   = 8'd0;
                krow_d = 8'd0;
                x_d    = 5'd0;
                y_d    = 5'd0;
            end
            KEY: begin
                x_d = 5'd0;
                y_d = 5'd0;
                if (key_load) ksr_d = subkey;
            end
            LOAD: {y_d, x_d} = {y_q, x_q} + 10'd1;
            WRITE: begin
                {y_d, x_d} = {y_q, x_q} + 10'd1;
                if (blk_end) begin
                    ksr_d = ksr_q << 1;
                    if (bx_q == LAST_BX) begin
                        bx_d   = 8'd0;
                        by_d   = by_q + 8'd1;
                        krow_d = (krow_q == LAST_KROW) ? 8'd0 : krow_q + 8'd1;
                    end else begin
                        bx_d = bx_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            bx_q   <= 8'd0;
            by_q   <= 8'd0;
            krow_q <= 8'd0;
            x_q    <= 5'd0;
            y_q    <= 5'd0;
            ksr_q  <= '0;
        end else begin
            bx_q   <= bx_d;
            by_q   <= by_d;
            krow_q <= krow_d;
            x_q    <= x_d;
            y_q    <= y_d;
            ksr_q  <= ksr_d;
        end
    end

endmodule

// File: tb/tb_diag_unrotation.sv
// Bench for diag_unrotation on a reduced 2x5-block frame: forward-shift encryptor
// model, per-cycle output schedule check, and in-SRAM round-trip check.
module tb_diag_unrotation;

    localparam int COLS    = 2;
    localparam int ROWS    = 5;
    localparam int KROWS   = 4;
    localparam int NBLK    = COLS * ROWS;
    localparam int FW      = 32 * COLS;
    localparam int WORDS   = FW * 32 * ROWS;
    localparam int BLK_CYC = 2050;
    localparam int NGRP    = (ROWS + KROWS - 1) / KROWS;
    localparam logic [19:0] BASE = 20'h0;
    localparam logic [40:0] IDLE_VEC = {2'b00, 3'b111, 36'h0};

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Run = 1'b0;
    logic [79:0] subkey = '0;
    logic        done, key_ack;
    logic [15:0] SRAM_DQ_in, SRAM_DQ_out;
    logic        SRAM_DQ_imp, SRAM_OE_N, SRAM_WE_N;
    logic [19:0] SRAM_ADDR;

    logic [15:0] mem   [WORDS];
    logic [15:0] enc   [WORDS];
    logic [15:0] plain [WORDS];
    logic [79:0] keys  [NGRP];
    logic        load_req = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    diag_unrotation #(
        .BLK_COLS (COLS),
        .BLK_ROWS (ROWS),
        .KEY_ROWS (KROWS),
        .BASE_ADDR(BASE)
    ) u_dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .subkey     (subkey),
        .done       (done),
        .key_ack    (key_ack),
        .SRAM_DQ_in (SRAM_DQ_in),
        .SRAM_DQ_out(SRAM_DQ_out),
        .SRAM_DQ_imp(SRAM_DQ_imp),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    // Asynchronous-read SRAM model.
    assign SRAM_DQ_in = (!SRAM_OE_N && (SRAM_ADDR < 20'(WORDS))) ? mem[SRAM_ADDR[13:0]] : 16'h0;

    always @(posedge Clk) begin
        if (load_req) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= enc[i];
        end else if (!SRAM_WE_N && !SRAM_DQ_imp && (SRAM_ADDR < 20'(WORDS))) begin
            mem[SRAM_ADDR[13:0]] <= SRAM_DQ_out;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pix_addr(input int bx, input int by, input int p);
        return int'(BASE) + (by * 32 + p / 32) * FW + bx * 32 + p % 32;
    endfunction

    function automatic logic key_bit(input int n);
        int by, bx, k;
        logic [79:0] kv;
        by = n / COLS;
        bx = n % COLS;
        k  = (by % KROWS) * COLS + bx;
        kv = keys[by / KROWS];
        return kv[79 - k];
    endfunction

    // Encryptor: plain (r,c) moves to (er,ec) under the chosen ring shift.
    task automatic fwd(input logic b, input int r, input int c, output int er, output int ec);
        if (!b) begin
            if (c == 31)      begin er = 0;     ec = 31 - r; end
            else if (r == 31) begin er = 31 - c; ec = 0;     end
            else              begin er = r + 1; ec = c + 1;  end
        end else begin
            if (c == 0)       begin er = 0;     ec = r;      end
            else if (r == 31) begin er = c;     ec = 31;     end
            else              begin er = r + 1; ec = c - 1;  end
        end
    endtask

    task automatic build_frame(input logic invert);
        int er, ec, base;
        for (int a = 0; a < WORDS; a++) plain[a] = invert ? ~16'(a) : 16'(a);
        for (int n = 0; n < NBLK; n++) begin
            base = pix_addr(n % COLS, n / COLS, 0);
            for (int r = 0; r < 32; r++) begin
                for (int c = 0; c < 32; c++) begin
                    fwd(key_bit(n), r, c, er, ec);
                    enc[base + er * FW + ec] = plain[base + r * FW + c];
                end
            end
        end
    endtask

    task automatic preload();
        load_req = 1'b1;
        @(posedge Clk);
        #1 load_req = 1'b0;
    endtask

    function automatic logic [40:0] act_vec();
        return {done, key_ack, SRAM_DQ_imp, SRAM_OE_N, SRAM_WE_N, SRAM_ADDR, SRAM_DQ_out};
    endfunction

    // t=0 is the KEY cycle of block 0; each block is KEY, 1024 LOAD, PRIME, 1024 WRITE.
    function automatic logic [40:0] exp_vec(input int t);
        int n, r, bx, by, a;
        logic d, k, imp, oe, we;
        logic [19:0] ad;
        logic [15:0] dq;
        d = 1'b0; k = 1'b0; imp = 1'b1; oe = 1'b1; we = 1'b1; ad = '0; dq = '0;
        if (t >= NBLK * BLK_CYC) begin
            d = 1'b1;
        end else begin
            n  = t / BLK_CYC;
            r  = t % BLK_CYC;
            bx = n % COLS;
            by = n / COLS;
            if (r == 0) begin
                k = (bx == 0) && (by % KROWS == 0);
            end else if (r <= 1024) begin
                oe = 1'b0;
                ad = 20'(pix_addr(bx, by, r - 1));
            end else if (r >= 1026) begin
                a   = pix_addr(bx, by, r - 1026);
                we  = 1'b0;
                imp = 1'b0;
                ad  = 20'(a);
                dq  = plain[a];
            end
        end
        return {d, k, imp, oe, we, ad, dq};
    endfunction

    task automatic run_frame(input string tag);
        int ksel, acks, errs, a;
        logic prev_ack;
        ksel = 0; acks = 0; prev_ack = 1'b0;
        subkey = keys[0];
        Run = 1'b1;
        @(posedge Clk);
        #1;
        // Four extra cycles with Run still high cover the held-DONE behaviour.
        for (int t = 0; t < NBLK * BLK_CYC + 4; t++) begin
            @(negedge Clk);
            if (prev_ack) begin
                ksel++;
                subkey = keys[ksel % NGRP];
            end
            prev_ack = key_ack;
            if (key_ack) acks++;
            check($sformatf("%s_cyc%0d", tag, t), 64'(act_vec()), 64'(exp_vec(t)));
        end
        check({tag, "_key_acks"}, 64'(acks), 64'(NGRP));
        Run = 1'b0;
        @(posedge Clk);
        #1 check({tag, "_back_idle"}, 64'(act_vec()), 64'(IDLE_VEC));
        for (int n = 0; n < NBLK; n++) begin
            errs = 0;
            for (int p = 0; p < 1024; p++) begin
                a = pix_addr(n % COLS, n / COLS, p);
                if (mem[a] !== plain[a]) errs++;
            end
            check($sformatf("%s_blk%0d_bad_words", tag, n), 64'(errs), 64'd0);
        end
    endtask

    initial begin
        // Reset dominates a high Run.
        Reset = 1'b0;
        Run   = 1'b1;
        repeat (3) @(posedge Clk);
        #1 check("reset_outputs", 64'(act_vec()), 64'(IDLE_VEC));
        Run   = 1'b0;
        Reset = 1'b1;
        @(posedge Clk);
        #1 check("idle_no_run", 64'(act_vec()), 64'(IDLE_VEC));

        // Frame A: all-zero key, every block down-right.
        keys[0] = '0;
        keys[1] = '0;
        build_frame(1'b0);
        check("pinA_enc0", 64'(enc[0]), 64'd2015);
        check("pinA_enc31", 64'(enc[31]), 64'd31);
        check("pinA_enc1", 64'(enc[1]), 64'd1951);
        preload();
        run_frame("A");
        check("A_word0", 64'(mem[0]), 64'd0);
        check("A_word31", 64'(mem[31]), 64'd31);

        // Frame B: block 0 down-left, block 1 down-right, second group from keys[1].
        keys[0] = 80'h8000_0000_0000_0000_0000;
        keys[1] = 80'hBEEF_CAFE_0123_4567_89AB;
        build_frame(1'b1);
        check("pinB_enc0", 64'(enc[0]), 64'h0000_0000_0000_FFFF);
        check("pinB_enc31", 64'(enc[31]), 64'h0000_0000_0000_F83F);
        check("pinB_enc32", 64'(enc[32]), 64'h0000_0000_0000_F800);
        preload();
        run_frame("B");
        check("B_word31", 64'(mem[31]), 64'h0000_0000_0000_FFE0);
        check("B_word32", 64'(mem[32]), 64'h0000_0000_0000_FFDF);

        // Frame C: reset during WRITE of block 5, then restart.
        subkey = keys[0];
        Run = 1'b1;
        @(posedge Clk);
        repeat (5 * BLK_CYC + 1126) @(posedge Clk);
        #1 check("mid_in_write", 64'(SRAM_WE_N), 64'd0);
        Reset = 1'b0;
        @(posedge Clk);
        #1 check("mid_reset_idle", 64'(act_vec()), 64'(IDLE_VEC));
        Reset = 1'b1;
        @(posedge Clk);
        #1 check("restart_key", 64'(act_vec()), 64'({2'b01, 3'b111, 36'h0}));
        @(posedge Clk);
        #1 check("restart_load0", 64'(act_vec()), 64'({2'b00, 3'b101, BASE, 16'h0}));
        @(posedge Clk);
        #1 check("restart_load1", 64'(SRAM_ADDR), 64'(BASE + 20'd1));
        Run = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/diag_unrotation.md
Name: diag_unrotation

Overview:
- Frame decryptor; exact inverse of the diagonal-rotation encryptor.
- Operates in place on a 640x480, 16-bit-per-pixel frame in external SRAM, one 32x32 block at a time.
- For each block: reads the block, applies the inverse border-ring rotation selected by one subkey bit, writes the block back to the same addresses.
- Sits beside the encryptor on the shared SRAM port; the top-level mux grants the port by Run.

Parameters:
- BLK_COLS, 20, blocks per block row.
- BLK_ROWS, 15, block rows per frame.
- KEY_ROWS, 4, block rows covered by one 80-bit subkey.
- BASE_ADDR, 20'h0, SRAM word address of pixel (0,0).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- Run  in  1  level; starts a frame when IDLE.
- subkey  in  80  current subkey; sampled when key_ack=1.
- done  out  1  high in DONE state.
- key_ack  out  1  one-cycle pulse; subkey consumed this edge.
- SRAM_DQ_in  in  16  SRAM read data.
- SRAM_DQ_out  out  16  SRAM write data.
- SRAM_DQ_imp  out  1  0 = drive DQ; 1 = high-Z.
- SRAM_ADDR  out  20  word address.
- SRAM_OE_N  out  1  active-low output enable.
- SRAM_WE_N  out  1  active-low write enable.

Behaviour:
- Reset and outputs:
  - Reset=0 at an edge forces IDLE and clears all counters and the key shift register, including mid-frame. Partially written blocks are not restored.
  - Outputs are decoded from state. Defaults: done=0, key_ack=0, SRAM_DQ_imp=1, SRAM_OE_N=1, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ_out=0.
- Counters: bx 0..BLK_COLS-1, by 0..BLK_ROWS-1, pixel x,y 0..31.
- Address: BASE_ADDR + 640*(32*by+y) + 32*bx + x, truncated to 20 bits. The 640 multiplier is 32*BLK_COLS.
- IDLE: go to KEY when Run=1.
- KEY (1 cycle):
  - If bx=0 and by%KEY_ROWS=0: key_ack=1 and ksr<=subkey.
  - Always go to LOAD with x=y=0.
- LOAD (1024 cycles):
  - OE_N=0; address from (by,y,x). SRAM_DQ_in is captured at the same edge.
  - b=ksr[79]. The captured pixel at encrypted position (y,x) is stored at buffer index dest(b,y,x).
  - x,y advance row-major. After (31,31), go to PRIME.
- dest(0,y,x) = undo down-right shift:
  - y=0, x<=30 -> (31-x,31)
  - y=0, x=31 -> (0,31)
  - y>=1, x=0 -> (31,31-y)
  - else -> (y-1,x-1)
- dest(1,y,x) = undo down-left shift:
  - y=0, x=0 -> (0,0)
  - y=0, x>=1 -> (x,0)
  - y>=1, x=31 -> (31,y)
  - else -> (y-1,x+1)
- dest must be a bijection for each b.
- PRIME (1 cycle): issue buffer read of index 0. Covers the 1-cycle synchronous RAM latency.
- WRITE (1024 cycles):
  - WE_N=0, DQ_imp=0, OE_N=1.
  - Address from (by,y,x); SRAM_DQ_out = buffer q for index (y,x). Read of the next index is issued in the same cycle.
  - After (31,31):
    - ksr<=ksr<<1.
    - Advance bx; on bx=BLK_COLS-1 wrap bx to 0 and increment by.
    - If this was the last block (bx=BLK_COLS-1, by=BLK_ROWS-1), go to DONE; else go to KEY.
- Bit usage: within a key group, the block at index k = (by%KEY_ROWS)*BLK_COLS + bx uses subkey[79-k]. The final group holds 3 rows, so it uses bits 79..20.
- Timing: 2050 cycles per block; 615000 cycles per frame plus IDLE/DONE.
- DONE: done=1; return to IDLE when Run=0. Run falling mid-frame is ignored; the frame completes.
- SRAM_OE_N and SRAM_WE_N are never low in the same cycle.

Decomposition:
- Package diag_rot_pkg holds:
  - BLK_DIM=32, FRAME_W=640, KEY_BITS=80.
  - The state enum {IDLE, KEY, LOAD, PRIME, WRITE, DONE}.
  - Function dest_idx(b,y,x) returning a 10-bit index. It is shared so the encryptor's model can use its inverse.
- Sub-module diag_blk_buf: 1024x16 simple dual-port RAM with synchronous read and one write port, inferable to block RAM.

Test Plan:
- Reset check: hold Reset=0 for 3 cycles with Run=1 -> state IDLE; OE_N=WE_N=DQ_imp=1; ADDR=0; key_ack=0.
- Single-bit-0 block: SRAM preloaded with a pixel pattern and its down-right encryption; subkey=80'h0; run -> after 2051 cycles block (0,0) equals the plain pattern, e.g. word 0 = plain[0][0] and word 31 = plain[0][31].
- Bit-1 inverse: subkey=80'h8000_0000_0000_0000_0000 with a down-left-encrypted block 0 -> block 0 restored; block 1 uses bit 78=0.
- Full-frame round trip: random frame, subkey sequence K0..K3, golden encryptor model -> after decrypt, all 307200 words equal the original.
  - key_ack pulses exactly 4 times: at by=0, 4, 8, 12.
  - done rises at cycle 615001 after Run.
- Mid-frame reset: assert Reset=0 during WRITE of block 5 -> next edge IDLE, WE_N=1; Run re-asserted -> restarts at ADDR=BASE_ADDR.
- Run held after done: keep Run=1 -> done stays 1 and no SRAM strobes; Run=0 -> IDLE on the next edge.
